// File: rtl/counter_arb_if.sv
// Requester-side bundle for counter_arb: per-requester request/operation/data
// going in, one-hot grant, completion pulse and captured result coming back.
interface counter_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    // Handshake: req[i] is a level held (with op/data stable) until done[i]
    // pulses; op/data are sampled only in the grant cycle. The requester must
    // drop req[i] by the edge after done[i], otherwise it competes again.
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       op;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;

    modport master (output req, op, data, input gnt, done, result);
    modport slave  (input req, op, data, output gnt, done, result);
endinterface

// File: rtl/counter_arb.sv
// Round-robin controller that serialises load / increment-burst requests from
// NREQ requesters onto one shared counter and returns the resulting value.
module counter_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    counter_arb_if.slave     rq,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_ld,
    output logic             cnt_inc,
    output logic [WIDTH-1:0] cnt_data,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_INC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] result_q;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_q;

    logic             found;
    logic [PW-1:0]    win;
    logic [NREQ-1:0]  win_onehot;
    logic [WIDTH-1:0] win_data;

    // Search starts just after the last winner, so it ends up lowest priority.
    always_comb begin
        int idx;
        idx        = 0;
        found      = 1'b0;
        win        = ptr;
        win_onehot = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && rq.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        win_onehot[win] = 1'b1;
        win_data        = rq.data[int'(win)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ptr      <= PW'(NREQ - 1);
            op_data  <= '0;
            rem      <= '0;
            result_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt_q   <= win_onehot;
                        ptr     <= win;
                        op_data <= win_data;
                        rem     <= win_data;
                        if (rq.op[win]) begin
                            state <= S_LOAD;
                        end else if (win_data != '0) begin
                            state <= S_INC;
                        end else begin
                            state  <= S_DONE;
                            done_q <= win_onehot;
                        end
                    end
                end
                S_LOAD: begin
                    state  <= S_DONE;
                    done_q <= gnt_q;
                end
                S_INC: begin
                    rem <= rem - 1'b1;
                    if (rem == WIDTH'(1)) begin
                        state  <= S_DONE;
                        done_q <= gnt_q;
                    end
                end
                S_DONE: begin
                    result_q <= cnt_q;
                    done_q   <= '0;
                    gnt_q    <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // cnt_q already holds the final value during DONE, so it is forwarded
    // directly there and the captured copy is shown afterwards.
    assign rq.result = (state == S_DONE) ? cnt_q : result_q;
    assign rq.gnt    = gnt_q;
    assign rq.done   = done_q;
    assign cnt_ld    = (state == S_LOAD);
    assign cnt_inc   = (state == S_INC);
    assign cnt_data  = op_data;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
endmodule

// File: doc/counter_arb.md
# counter_arb

Round-robin controller that shares one 8-bit `counter` instance between `NREQ` requesters. Each requester asks for either a load of an 8-bit value or a burst of N increments. The block serialises these operations onto the counter's `ld`/`inc`/`data_in` pins and returns the resulting counter value with a one-cycle completion pulse. It sits directly in front of the counter; the counter's `q` feeds back into this block.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 8: data/counter width; must equal the counter width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous reset, active-low (asserted when 0).
- `req` in NREQ: per-requester request, level; held high until the matching `done`.
- `op` in NREQ: per-requester operation, 1 = load, 0 = increment burst; sampled at grant.
- `data` in NREQ*WIDTH: requester i uses bits [i*WIDTH +: WIDTH]. Load value, or burst length N for increments; sampled at grant.
- `cnt_q` in WIDTH: counter `q` feedback.
- `cnt_ld` out 1: drives counter `ld`.
- `cnt_inc` out 1: drives counter `inc`.
- `cnt_data` out WIDTH: drives counter `data_in`.
- `gnt` out NREQ: one-hot owner of the current operation; all-zero in IDLE.
- `done` out NREQ: one-cycle completion pulse to the owner.
- `result` out WIDTH: `cnt_q` captured at completion; valid while `done` is nonzero and held afterwards.
- `busy` out 1: high in every state except IDLE.

## Operation
- Four states: IDLE, LOAD, INC, DONE.
- **IDLE:**
  - If any `req` bit is set, pick the winner round-robin, starting from `ptr+1` (wrapping modulo NREQ).
  - Register `gnt` (one-hot), `ptr` (winner index), `op_data` (the winner's `data` slice) and `rem` (= `op_data`).
  - Next state:
    - `op`=1: LOAD.
    - `op`=0 and `data`≠0: INC.
    - `op`=0 and `data`=0: DONE (zero-length burst; the counter is untouched).
- **LOAD:** `cnt_ld`=1 and `cnt_data`=`op_data` for exactly one cycle, then DONE.
- **INC:** `cnt_inc`=1 every cycle. `rem` decrements each cycle; go to DONE when `rem`=1. Exactly N increment pulses are issued.
- **DONE:**
  - `done[ptr]`=1 and `result`<=`cnt_q`. `cnt_q` already reflects the last ld/inc because the counter updated on the edge ending the previous state.
  - Next state: IDLE. `gnt` clears on leaving DONE.
- **Outputs:**
  - `cnt_ld` and `cnt_inc` decode combinationally from state; they are never both high.
  - `cnt_data`=`op_data` in all states.
- **Counter arithmetic:** wraps modulo 2^WIDTH (255+1=0). The block does no saturation and does not detect wrap.
- **Request rules:**
  - `req`/`op`/`data` are ignored outside IDLE.
  - Dropping `req` mid-operation does not abort; the operation completes and `done` still pulses.
  - A requester must drop `req` on the edge after `done` is seen, or it is granted again.
- **Fairness:** the most recent winner has the lowest priority in the next IDLE arbitration.
- **Reset values:**
  - State = IDLE; `ptr` = NREQ-1, so requester 0 has top priority after reset.
  - `gnt`, `done`, `rem`, `op_data` and `result` = 0.
  - `cnt_ld`, `cnt_inc`, `cnt_data` and `busy` = 0.
- **Reset mid-operation:** all of the above take effect immediately (asynchronous). Remaining increments are discarded and no `done` is issued.

## Timing
- **Load:** `req` seen in IDLE at cycle 0; `cnt_ld` in cycle 1; `done`/`result` in cycle 2; IDLE in cycle 3. Total 3 cycles per load, including the arbitration cycle.
- **Increment burst N≥1:** `cnt_inc` in cycles 1..N; `done` in cycle N+1. Total N+2 cycles.
- **Increment burst N=0:** `done` in cycle 1; `result` equals the unchanged `cnt_q`.
- **Back-to-back:** the minimum gap between operations is one IDLE cycle. The next grant is evaluated in the IDLE cycle that follows DONE.
- **Simultaneous requests:** all wait in line; each is served in round-robin order with no starvation. The worst-case wait is NREQ-1 operations.
- **Pulse widths:** `done` is exactly one cycle. `busy` is high from cycle 1 through the DONE cycle inclusive.

## Test plan
- **Reset:** hold `rst`=0 with `req`=4'b1111 → all outputs 0 and no grant. Release → requester 0 is granted first.
- **Single load:** requester 2, `op`=1, `data`=8'hA5 → `cnt_ld` high for 1 cycle with `cnt_data`=A5; `done`=4'b0100 two cycles after the request is seen; `result`=A5.
- **Burst with wrap:** preload FE, then requester 1 increments with N=3 → exactly 3 `cnt_inc` pulses; `result`=8'h01; the burst takes 5 cycles from grant cycle to `done`. Also N=0 → no `cnt_inc`; `done` in cycle 1; `result` unchanged.
- **Round-robin:** all 4 requesters hold loads with distinct values (10, 20, 30, 40) → grants in order 0,1,2,3. Then re-assert 0 and 3 together after 3 was last served → 0 wins.
- **Ignored inputs:** change `op`/`data` of the owner during INC → no effect on the burst. Drop `req` mid-burst → the burst still completes with `done`.
- **Async reset mid-burst:** assert `rst` during INC with `rem`=5 → `cnt_inc` drops immediately, no `done` is issued, and the block is in IDLE when reset releases.
